// File: rtl/codificador_pkg.sv
// codificador_pkg: shared FSM state type and default sizing for the debounced keypad encoder.
package codificador_pkg;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;
  localparam int DEF_N_KEYS = 10;
  localparam int DEF_CODE_W = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_CYCLES = 8;
endpackage

// File: rtl/codificador_priori_n.sv
// codificador_priori_n: combinational priority encoder, highest asserted index wins.
module codificador_priori_n #(
  parameter int N_KEYS = 10,
  parameter int CODE_W = 4
) (
  input  logic [N_KEYS-1:0] keys,
  output logic [CODE_W-1:0] code,
  output logic              any
);
  always_comb begin
    code = '0;
    for (int i = 0; i < N_KEYS; i++) code = keys[i] ? CODE_W'(i) : code;
  end
  assign any = |keys;
endmodule

// File: rtl/codificador_teclado_debounce.sv
// codificador_teclado_debounce: synchronized, debounced keypad priority encoder with one pulse per press.
// Defining CODIFICADOR_REPEAT_EN adds auto-repeat pulses every REPEAT_CYCLES edges while a key is held.
module codificador_teclado_debounce
  import codificador_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int CODE_W          = DEF_CODE_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [N_KEYS-1:0] teclado,
  input  logic              enablen,
  output logic [CODE_W-1:0] BCD,
  output logic              dado_valido,
  output logic              tecla_presa
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  if (N_KEYS < 2 || N_KEYS > 16) begin : g_bad_keys
    $error("N_KEYS must be in 2..16");
  end
  if ((1 << CODE_W) < N_KEYS) begin : g_bad_code
    $error("CODE_W too narrow for N_KEYS");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rep
    $error("REPEAT_CYCLES must be at least 1");
  end
  logic [N_KEYS-1:0] sync1, s;
  logic [CODE_W-1:0] code, cand, cand_d, bcd_d;
  logic              any, pulse_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  state_t            state, state_d;
`ifdef CODIFICADOR_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep, rep_d;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) rep <= '0;
    else rep <= rep_d;
`endif
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= teclado;
      s     <= sync1;
    end
  codificador_priori_n #(.N_KEYS(N_KEYS), .CODE_W(CODE_W)) u_priori (
    .keys(s),
    .code(code),
    .any (any)
  );
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      BCD         <= '0;
      dado_valido <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      cand        <= cand_d;
      BCD         <= bcd_d;
      dado_valido <= pulse_d;
    end
  // cnt never exceeds DEBOUNCE_CYCLES: every branch that reaches it leaves the counting state
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cand_d  = cand;
    bcd_d   = BCD;
    pulse_d = 1'b0;
`ifdef CODIFICADOR_REPEAT_EN
    rep_d   = '0;
`endif
    if (enablen) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          state_d = DEBOUNCE;
          cand_d  = code;
          cnt_d   = CNT_ONE;
        end
        DEBOUNCE: if (!any) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (code != cand) begin
          cand_d = code;
          cnt_d  = CNT_ONE;
        end else if (cnt == CNT_MAX) begin
          state_d = HELD;
          cnt_d   = '0;
          bcd_d   = cand;
          pulse_d = 1'b1;
        end else cnt_d = cnt + 1'b1;
        HELD: if (!any) begin
          state_d = RELEASE;
          cnt_d   = CNT_ONE;
        end
`ifdef CODIFICADOR_REPEAT_EN
        else if (code != cand) cand_d = code;
        else if (rep == REP_MAX) begin
          bcd_d   = cand;
          pulse_d = 1'b1;
        end else rep_d = rep + 1'b1;
`endif
        RELEASE: if (any) begin
          state_d = HELD;
          cnt_d   = '0;
          cand_d  = code;
        end else if (cnt == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt + 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end
  assign tecla_presa = (state == HELD) || (state == RELEASE);
endmodule

// File: tb/tb_codificador_teclado_debounce.sv
// tb_codificador_teclado_debounce: directed scenarios plus random key traffic checked against a run-length model.
module tb_codificador_teclado_debounce;
  localparam int D = 4;
  localparam int R = 8;
  logic       clock = 1'b0;
  logic       resetn, enablen;
  logic [9:0] teclado;
  logic [3:0] BCD;
  logic       dado_valido, tecla_presa;
  int n_checks = 0, n_fail = 0;
  logic [9:0] m_s1, m_s;
  int  run, run_code, zrun, rr, hold_code, m_bcd;
  bit  held, m_pulse;
  codificador_teclado_debounce #(.N_KEYS(10), .CODE_W(4), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clock(clock), .resetn(resetn), .teclado(teclado), .enablen(enablen),
    .BCD(BCD), .dado_valido(dado_valido), .tecla_presa(tecla_presa)
  );
  always #5 clock = ~clock;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int enc(logic [9:0] v);
    enc = 0;
    for (int i = 0; i < 10; i++) if (v[i]) enc = i;
  endfunction
  task automatic mreset();
    m_s1 = '0; m_s = '0; run = 0; run_code = 0; zrun = 0; rr = 0;
    hold_code = 0; m_bcd = 0; held = 0; m_pulse = 0;
  endtask
  // A press is accepted after D+1 consecutive edges of the same nonzero code; release after D+1 zero edges.
  task automatic step();
    int c;
    c = enc(m_s);
    m_pulse = 0;
    if (enablen) begin
      held = 0; run = 0; zrun = 0; rr = 0;
    end else if (held) begin
      if (m_s == 0) begin
        zrun++; rr = 0;
        if (zrun == D + 1) begin held = 0; run = 0; zrun = 0; end
      end else if (zrun > 0) begin
        zrun = 0; rr = 0; hold_code = c;
      end else if (c != hold_code) begin
        hold_code = c; rr = 0;
      end else begin
        rr++;
`ifdef CODIFICADOR_REPEAT_EN
        if (rr == R) begin rr = 0; m_pulse = 1; m_bcd = hold_code; end
`endif
      end
    end else begin
      if (m_s == 0) run = 0;
      else if (run > 0 && c == run_code) run++;
      else begin run = 1; run_code = c; end
      if (run == D + 1) begin
        held = 1; m_pulse = 1; m_bcd = c; run = 0; rr = 0; zrun = 0; hold_code = c;
      end
    end
    m_s = m_s1;
    m_s1 = teclado;
  endtask
  task automatic cmp();
    check("bcd", 32'(BCD), 32'(m_bcd));
    check("valid", 32'(dado_valido), 32'(m_pulse));
    check("held", 32'(tecla_presa), 32'(held));
  endtask
  task automatic cyc();
    @(posedge clock);
    if (resetn) step(); else mreset();
    @(negedge clock);
    cmp();
  endtask
  task automatic hold(logic [9:0] pat, int n, output int np, output int first);
    np = 0; first = -1;
    teclado = pat;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (dado_valido) begin
        np++;
        if (first < 0) first = i;
      end
    end
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    mreset();
    check("rst_bcd", 32'(BCD), 0);
    check("rst_valid", 32'(dado_valido), 0);
    check("rst_held", 32'(tecla_presa), 0);
    cyc();
    resetn = 1'b1;
  endtask
  initial begin
    int np, first, tot, exp_rep;
    logic [9:0] pat;
    resetn = 1'b0; enablen = 1'b0; teclado = '0;
    mreset();
    @(negedge clock);
    do_reset();
    hold(10'b0000100000, 10, np, first);
    check("r030_n", 32'(np), 1);
    check("r030_lat", 32'(first), 6);
    check("r030_bcd", 32'(BCD), 5);
    check("r030_held", 32'(tecla_presa), 1);
    hold('0, 8, np, first);
    check("r030_rel", 32'(tecla_presa), 0);
    hold(10'b1000001001, 12, np, first);
    check("r031_n", 32'(np), 1);
    check("r031_bcd", 32'(BCD), 9);
    hold('0, 8, np, first);
    hold(10'b0000001000, 3, np, first); tot = np;
    hold('0, 1, np, first); tot += np;
    hold(10'b0000001000, 3, np, first); tot += np;
    hold('0, 8, np, first); tot += np;
    check("r032_n", 32'(tot), 0);
    check("r032_bcd", 32'(BCD), 9);
    enablen = 1'b1;
    hold(10'b0010000000, 20, np, first);
    check("r033_dis_n", 32'(np), 0);
    enablen = 1'b0;
    hold(10'b0010000000, 10, np, first);
    check("r033_n", 32'(np), 1);
    check("r033_bcd", 32'(BCD), 7);
    hold('0, 8, np, first);
    hold(10'b0000000100, 10, np, first);
    check("r034_pre_n", 32'(np), 1);
    check("r034_pre_held", 32'(tecla_presa), 1);
    do_reset();
    hold(10'b0000000100, 10, np, first);
    check("r034_n", 32'(np), 1);
    check("r034_lat", 32'(first), 6);
    check("r034_bcd", 32'(BCD), 2);
    hold('0, 8, np, first);
`ifdef CODIFICADOR_REPEAT_EN
    exp_rep = 3;
`else
    exp_rep = 1;
`endif
    hold(10'b0000010000, 30, np, first);
    check("r035_n", 32'(np), 32'(exp_rep));
    check("r035_bcd", 32'(BCD), 4);
    for (int seg = 0; seg < 120; seg++) begin
      case ($urandom_range(0, 3))
        0: pat = '0;
        3: pat = 10'($urandom_range(1, 1023));
        default: begin pat = '0; pat[$urandom_range(0, 9)] = 1'b1; end
      endcase
      enablen = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) do_reset();
      hold(pat, $urandom_range(1, 12), np, first);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
